// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: machine word and the RAM handshake status seen by the arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/memory_arbiter.sv
// Arbitrates icache fetches and dcache loads/stores onto a single RAM port.
// Completion is a one-cycle low pulse on iwait/dwait with load data valid in that cycle.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISERV = 2'd1;
    localparam logic [1:0] DSERV = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          dreq;

    assign dreq = dREN | dWEN;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // A dropped request takes priority over ACCESS so an abandoned op never pulses.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (dreq && (!iREN || (starve_q < SMAX)))
                    state_d = DSERV;
                else if (iREN)
                    state_d = ISERV;
            end
            DSERV: begin
                if (!dreq) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d = IDLE;
                    if (iREN && (starve_q < SMAX))
                        starve_d = starve_q + 1'b1;
                end else if (ramstate == ERROR) begin
                    state_d = IDLE;
                end
            end
            ISERV: begin
                if (!iREN || (ramstate == ERROR)) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    state_d  = IDLE;
                    starve_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            DSERV: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else begin
                    ramREN = 1'b1;
                end
                if (dreq && (ramstate == ACCESS)) begin
                    dwait = 1'b0;
                    dload = ramload;
                end
            end
            ISERV: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                if (iREN && (ramstate == ACCESS)) begin
                    iwait = 1'b0;
                    iload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter: requester tasks push expected completions,
// a RAM model answers the RAM port, and a monitor pops and compares on every wait-low pulse.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int TMO = 200;

    logic      CLK = 1'b0;
    logic      nRST;
    logic      iREN, dREN, dWEN;
    word_t     iaddr, daddr, dstore;
    logic      iwait, dwait, ramREN, ramWEN;
    word_t     iload, dload, ramaddr, ramstore, ramload;
    ramstate_t ramstate;

    memory_arbiter #(.STARVE_MAX(3)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit    wr;
        word_t addr;
        word_t data;
    } exp_t;

    exp_t  iq[$];
    exp_t  dq[$];
    byte   order_q[$];
    bit    order_on = 1'b0;
    int    errors = 0;
    int    checks = 0;

    word_t ram_mem[word_t];
    word_t ref_mem[word_t];
    int    lat_fix = -1;
    int    err_pct = 0;
    bit    err_next = 1'b0;
    bit    hold_busy = 1'b0;

    function automatic word_t fill(word_t a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic word_t ref_rd(word_t a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    function automatic word_t ram_rd(word_t a);
        return ram_mem.exists(a) ? ram_mem[a] : fill(a);
    endfunction

    function automatic void chk(string name, word_t act, word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // RAM model: latency counted from the first enabled cycle, ERROR injectable
    initial begin
        int cnt, lat;
        cnt = 0; lat = 0;
        ramstate = FREE;
        ramload  = '0;
        forever begin
            @(negedge CLK);
            if (ramstate == ACCESS && ramWEN) ram_mem[ramaddr] = ramstore;
            @(posedge CLK);
            #2;
            if (!(ramREN || ramWEN) || !nRST) begin
                cnt = 0; ramstate = FREE; ramload = '0;
            end else begin
                if (cnt == 0) lat = (lat_fix >= 0) ? lat_fix : $urandom_range(0, 3);
                if (hold_busy || cnt < lat) begin
                    ramstate = BUSY; ramload = '0; cnt++;
                end else if (err_next || ($urandom_range(0, 99) < err_pct)) begin
                    err_next = 1'b0; ramstate = ERROR; ramload = '0; cnt = 0;
                end else begin
                    ramstate = ACCESS; ramload = ramREN ? ram_rd(ramaddr) : '0; cnt = 0;
                end
            end
        end
    end

    // Monitor: every wait-low pulse must match the oldest expectation of that requester
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!nRST) continue;
            chk("single_wait_low", {31'b0, (!iwait && !dwait)}, 32'd0);
            if (iwait && iload != '0) chk("iload_outside_pulse", iload, 32'd0);
            if (dwait && dload != '0) chk("dload_outside_pulse", dload, 32'd0);
            if (!iwait) begin
                if (iq.size() == 0) begin
                    chk("i_unexpected_pulse", {31'b0, iwait}, 32'd1);
                end else begin
                    e = iq.pop_front();
                    chk("iload", iload, e.data);
                    chk("i_ramaddr", ramaddr, e.addr);
                    chk("i_ramREN", {31'b0, ramREN}, 32'd1);
                end
                if (order_on && order_q.size() > 0) chk("grant_order", 32'(byte'("I")), 32'(order_q.pop_front()));
            end
            if (!dwait) begin
                if (dq.size() == 0) begin
                    chk("d_unexpected_pulse", {31'b0, dwait}, 32'd1);
                end else begin
                    e = dq.pop_front();
                    chk("d_ramaddr", ramaddr, e.addr);
                    chk("d_ramWEN", {31'b0, ramWEN}, {31'b0, e.wr});
                    chk("d_ramREN", {31'b0, ramREN}, {31'b0, !e.wr});
                    if (e.wr) chk("ramstore", ramstore, e.data);
                    else      chk("dload", dload, e.data);
                end
                if (order_on && order_q.size() > 0) chk("grant_order", 32'(byte'("D")), 32'(order_q.pop_front()));
            end
        end
    end

    // Requester tasks start and end at posedge+1 so consecutive calls are back-to-back.
    task automatic i_req(input word_t a, output int n);
        iREN = 1'b1; iaddr = a;
        iq.push_back('{wr: 1'b0, addr: a, data: ref_rd(a)});
        n = 0;
        forever begin
            @(negedge CLK);
            if (!iwait) break;
            n++;
            if (n > TMO) begin
                chk("i_timeout", {31'b0, iwait}, 32'd0);
                void'(iq.pop_back());
                break;
            end
        end
        @(posedge CLK); #1;
        iREN = 1'b0;
    endtask

    task automatic d_req(input bit wr, input bit both, input word_t a, input word_t v, output int n);
        dREN = !wr || both; dWEN = wr; daddr = a; dstore = v;
        if (wr) begin
            dq.push_back('{wr: 1'b1, addr: a, data: v});
            ref_mem[a] = v;
        end else begin
            dq.push_back('{wr: 1'b0, addr: a, data: ref_rd(a)});
        end
        n = 0;
        forever begin
            @(negedge CLK);
            if (!dwait) break;
            n++;
            if (n > TMO) begin
                chk("d_timeout", {31'b0, dwait}, 32'd0);
                void'(dq.pop_back());
                break;
            end
        end
        @(posedge CLK); #1;
        dREN = 1'b0; dWEN = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    initial begin
        int n, ni, nd;
        nRST = 1'b0;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        #12;
        chk("rst_iwait", {31'b0, iwait}, 32'd1);
        chk("rst_dwait", {31'b0, dwait}, 32'd1);
        chk("rst_ramen", {30'b0, ramREN, ramWEN}, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_loads", iload | dload, 32'd0);
        @(posedge CLK); #1;
        nRST = 1'b1;

        // Fetch with RAM ACCESS two cycles after ramREN
        lat_fix = 2;
        ram_mem[32'h40] = 32'h8C220000;
        ref_mem[32'h40] = 32'h8C220000;
        i_req(32'h40, n);
        chk("i_latency", n, 32'd3);

        // Write: strobe latency and store data checked at completion, then read back
        d_req(1'b1, 1'b0, 32'h80, 32'hDEADBEEF, n);
        chk("d_wr_latency", n, 32'd3);
        d_req(1'b0, 1'b0, 32'h80, 32'h0, n);
        d_req(1'b1, 1'b1, 32'h84, 32'h12345678, n);
        d_req(1'b0, 1'b0, 32'h84, 32'h0, n);

        // One ERROR: silent retry from IDLE, completes on the next ACCESS
        lat_fix = 1; err_next = 1'b1;
        d_req(1'b0, 1'b0, 32'h88, 32'h0, n);
        chk("d_err_retry_latency", n, 32'd5);

        // Simultaneous requests, then starvation limit with iREN held
        do_reset();
        order_q = '{"D", "D", "D", "I", "D"};
        order_on = 1'b1;
        fork
            i_req(32'h10, ni);
            for (int k = 0; k < 4; k++) d_req(1'b0, 1'b0, 32'h1000 + 32'(k * 4), 32'h0, nd);
        join
        order_on = 1'b0;
        chk("order_drained", order_q.size(), 32'd0);
        // starve must be back at 0: with both pending, data wins again
        order_q = '{"D", "I"};
        order_on = 1'b1;
        fork
            i_req(32'h14, ni);
            d_req(1'b0, 1'b0, 32'h1010, 32'h0, nd);
        join
        order_on = 1'b0;
        chk("order2_drained", order_q.size(), 32'd0);

        // Fetch abandoned by requester: no pulse, enables drop
        hold_busy = 1'b1;
        iREN = 1'b1; iaddr = 32'h20;
        repeat (3) @(posedge CLK);
        #1 iREN = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        chk("abort_ramREN", {31'b0, ramREN}, 32'd0);

        // Async reset in ISERV with RAM BUSY
        @(posedge CLK); #1;
        iREN = 1'b1; iaddr = 32'h44;
        repeat (3) @(posedge CLK);
        #3 nRST = 1'b0;
        #1;
        chk("arst_iwait", {31'b0, iwait}, 32'd1);
        chk("arst_ramREN", {31'b0, ramREN}, 32'd0);
        chk("arst_ramaddr", ramaddr, 32'd0);
        iREN = 1'b0; hold_busy = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            chk("post_rst_idle", {30'b0, ramREN, ramWEN}, 32'd0);
        end
        @(posedge CLK); #1;

        // Randomized concurrent traffic with random latency and occasional ERROR
        lat_fix = -1; err_pct = 10;
        fork
            for (int k = 0; k < 60; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
                i_req(word_t'($urandom_range(0, 63)) * 4, ni);
            end
            for (int k = 0; k < 60; k++) begin
                int op;
                op = $urandom_range(0, 3);
                repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
                d_req(op[0], op == 3, 32'h1000 + word_t'($urandom_range(0, 15)) * 4, $urandom, nd);
            end
        join
        repeat (3) @(posedge CLK);
        chk("iq_empty", iq.size(), 32'd0);
        chk("dq_empty", dq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
